// File: rtl/dec_arbiter.sv
//-----------------------------------------------------------------------------
// dec_arbiter
//   Round-robin arbiter and sequencer sharing one DecryptionBlock between
//   requester A (SD read path) and requester B (host/bypass path).
//   The winner's ciphertext and key are captured, the core is started with a
//   one-cycle enable, its busy flag is tracked through start and completion,
//   and the plaintext is returned to the owner with a one-cycle done pulse.
//   A core that never starts or never finishes is aborted with err=1.
//
// Ports
//   clk_i, n_rst_i            clock, asynchronous active-low reset
//   req_x_i, data_x_i, key_x_i requester x (a/b) request and operands
//   ack_x_o, done_x_o         requester x operand-captured / result pulses
//   data_out_o, err_o         result of last completed job, abort flag
//   owner_o, arb_busy_o       current owner (0=A, 1=B), not-idle flag
//   dec_enable_o, dec_data_o, dec_key_o   core start pulse and operands
//   dec_busy_i, dec_result_i  core busy flag and plaintext
//
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module dec_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic         req_a_i,
  input  logic [127:0] data_a_i,
  input  logic [127:0] key_a_i,
  output logic         ack_a_o,
  output logic         done_a_o,
  input  logic         req_b_i,
  input  logic [127:0] data_b_i,
  input  logic [127:0] key_b_i,
  output logic         ack_b_o,
  output logic         done_b_o,
  output logic [127:0] data_out_o,
  output logic         err_o,
  output logic         owner_o,
  output logic         arb_busy_o,
  output logic         dec_enable_o,
  output logic [127:0] dec_data_o,
  output logic [127:0] dec_key_o,
  input  logic         dec_busy_i,
  input  logic [127:0] dec_result_i
);

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DELIVER    = 3'd4
  } state_e;

  state_e       state_q;
  logic         prio_q;       // side that wins a tie: 0 = A, 1 = B
  logic         owner_q;
  logic [7:0]   cnt_q;
  logic         ack_a_q;
  logic         ack_b_q;
  logic         done_a_q;
  logic         done_b_q;
  logic         err_q;
  logic         busy_q;
  logic         en_q;
  logic [127:0] data_out_q;
  logic [127:0] dec_data_q;
  logic [127:0] dec_key_q;

  logic [7:0]   cnt_d;
  logic         timeout_d;
  logic         grant_b_d;

  always_comb begin
    // Saturating increment: the counter never wraps back below the limit.
    cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    timeout_d = (cnt_d == C_TIMEOUT);
    // B wins when it is the only requester or when both ask and B has priority.
    grant_b_d = req_b_i & (~req_a_i | prio_q);
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= 8'd0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      data_out_q <= '0;
      dec_data_q <= '0;
      dec_key_q  <= '0;
    end else begin
      // Pulse outputs default low; they are raised only on the transition
      // into the state they belong to, so each lasts exactly one cycle.
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      en_q     <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_a_i || req_b_i) begin
            owner_q    <= grant_b_d;
            dec_data_q <= grant_b_d ? data_b_i : data_a_i;
            dec_key_q  <= grant_b_d ? key_b_i  : key_a_i;
            cnt_q      <= 8'd0;
            ack_a_q    <= ~grant_b_d;
            ack_b_q    <= grant_b_d;
            en_q       <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          state_q <= S_WAIT_START;
        end

        S_WAIT_START: begin
          // A low busy here only means the core has not started yet.
          if (dec_busy_i) begin
            state_q <= S_WAIT_DONE;
          end else begin
            cnt_q <= cnt_d;
            if (timeout_d) begin
              data_out_q <= '0;
              err_q      <= 1'b1;
              done_a_q   <= ~owner_q;
              done_b_q   <= owner_q;
              state_q    <= S_DELIVER;
            end
          end
        end

        S_WAIT_DONE: begin
          if (!dec_busy_i) begin
            data_out_q <= dec_result_i;
            err_q      <= 1'b0;
            done_a_q   <= ~owner_q;
            done_b_q   <= owner_q;
            state_q    <= S_DELIVER;
          end else begin
            cnt_q <= cnt_d;
            if (timeout_d) begin
              data_out_q <= '0;
              err_q      <= 1'b1;
              done_a_q   <= ~owner_q;
              done_b_q   <= owner_q;
              state_q    <= S_DELIVER;
            end
          end
        end

        S_DELIVER: begin
          prio_q  <= ~owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_a_o      = ack_a_q;
  assign ack_b_o      = ack_b_q;
  assign done_a_o     = done_a_q;
  assign done_b_o     = done_b_q;
  assign err_o        = err_q;
  assign owner_o      = owner_q;
  assign arb_busy_o   = busy_q;
  assign dec_enable_o = en_q;
  assign data_out_o   = data_out_q;
  assign dec_data_o   = dec_data_q;
  assign dec_key_o    = dec_key_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_arbiter.sv
//-----------------------------------------------------------------------------
// tb_dec_arbiter
//   Self-checking bench for dec_arbiter with a behavioural decryption core.
//   Known operand pair returns the reference plaintext; any other pair
//   returns a simple keyed scramble so results stay operand-dependent.
//
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_dec_arbiter;

  localparam int T = 20;
  localparam logic [127:0] VEC_D = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
  localparam logic [127:0] VEC_K = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;
  localparam logic [127:0] VEC_P = 128'h7d8ae0f7cfa0a6cb09fb5d05a8ec586d;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [127:0] data_a = '0, key_a = '0, data_b = '0, key_b = '0;
  logic         ack_a, ack_b, done_a, done_b, err, owner, arb_busy, dec_enable;
  logic [127:0] data_out, dec_data, dec_key;
  logic         dec_busy = 1'b0;
  logic [127:0] dec_result = '0;

  int passed = 0;
  int total  = 0;
  int ncyc   = 0;

  // core model configuration (written by tests) and state (written by core)
  int core_mode = 0;   // 0 normal, 1 never starts, 2 never finishes
  int core_s = 2, core_l = 3, clr_req = 0;
  int core_phase = 0, core_cnt = 0, core_ll = 0, clr_ack = 0;
  logic [127:0] core_d = '0, core_k = '0;

  dec_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .req_a_i(req_a), .data_a_i(data_a), .key_a_i(key_a), .ack_a_o(ack_a), .done_a_o(done_a),
    .req_b_i(req_b), .data_b_i(data_b), .key_b_i(key_b), .ack_b_o(ack_b), .done_b_o(done_b),
    .data_out_o(data_out), .err_o(err), .owner_o(owner), .arb_busy_o(arb_busy),
    .dec_enable_o(dec_enable), .dec_data_o(dec_data), .dec_key_o(dec_key),
    .dec_busy_i(dec_busy), .dec_result_i(dec_result)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_plain(input logic [127:0] d, input logic [127:0] k);
    if (d == VEC_D && k == VEC_K) return VEC_P;
    return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Core: busy rises core_s cycles after the enable is seen, falls core_l later.
  initial begin
    forever begin
      @(negedge clk);
      ncyc = ncyc + 1;
      if (!n_rst || clr_req != clr_ack) begin
        clr_ack    = clr_req;
        dec_busy   = 1'b0;
        core_phase = 0;
      end else begin
        case (core_phase)
          0: if (dec_enable === 1'b1 && core_mode != 1) begin
               core_d = dec_data; core_k = dec_key;
               core_cnt = core_s; core_ll = core_l; core_phase = 1;
             end
          1: begin
               core_cnt = core_cnt - 1;
               if (core_cnt == 0) begin dec_busy = 1'b1; core_cnt = core_ll; core_phase = 2; end
             end
          2: if (core_mode != 2) begin
               core_cnt = core_cnt - 1;
               if (core_cnt == 0) begin
                 dec_busy = 1'b0; dec_result = ref_plain(core_d, core_k); core_phase = 0;
               end
             end
          default: core_phase = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // which: 0 any ack, 1 any done, 2 arbiter idle, 3 core idle
  task automatic wait_ev(input int which, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      case (which)
        0: found = (ack_a === 1'b1) || (ack_b === 1'b1);
        1: found = (done_a === 1'b1) || (done_b === 1'b1);
        2: found = (arb_busy === 1'b0);
        3: found = (core_phase == 0) && (dec_busy == 1'b0);
        default: found = 1'b0;
      endcase
      if (found) break;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic run_a(input logic [127:0] d, input logic [127:0] k,
                       output int a_n, output bit got_ack, output bit got_done);
    bit f;
    wait_ev(3, 200, f);
    wait_ev(2, 200, f);
    data_a = d; key_a = k; req_a = 1'b1;
    tick();
    got_ack = (ack_a === 1'b1) && (ack_b === 1'b0);
    a_n = ncyc;
    req_a = 1'b0;
    wait_ev(1, 200, got_done);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    total++; if (data_out !== '0) $display("FAIL reset_data_out: got %h want 0", data_out); else passed++;
    total++; if (dec_data !== '0) $display("FAIL reset_dec_data: got %h want 0", dec_data); else passed++;
    total++; if (dec_key !== '0) $display("FAIL reset_dec_key: got %h want 0", dec_key); else passed++;
    total++; if ({dec_enable, ack_a, ack_b, done_a, done_b, err, owner, arb_busy} !== 8'h00)
      $display("FAIL reset_flags: got %b want 00000000", {dec_enable, ack_a, ack_b, done_a, done_b, err, owner, arb_busy});
    else passed++;
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single_a();
    bit found; int a_n;
    core_mode = 0; core_s = 2; core_l = 5;
    wait_ev(2, 50, found);
    data_a = VEC_D; key_a = VEC_K; req_a = 1'b1;
    tick();
    total++; if (!(ack_a === 1'b1 && ack_b === 1'b0 && dec_enable === 1'b1))
      $display("FAIL single_ack: got ack_a=%b ack_b=%b en=%b want 1 0 1", ack_a, ack_b, dec_enable);
    else passed++;
    total++; if (dec_data !== VEC_D || dec_key !== VEC_K || owner !== 1'b0)
      $display("FAIL single_operands: got %h/%h owner=%b want %h/%h owner=0", dec_data, dec_key, owner, VEC_D, VEC_K);
    else passed++;
    a_n = ncyc; req_a = 1'b0;
    wait_ev(1, 100, found);
    total++; if (!found) $display("FAIL single_done_seen: got none want done_a"); else passed++;
    total++; if (!(done_a === 1'b1 && done_b === 1'b0 && err === 1'b0))
      $display("FAIL single_done: got done_a=%b done_b=%b err=%b want 1 0 0", done_a, done_b, err);
    else passed++;
    total++; if (data_out !== VEC_P) $display("FAIL single_data_out: got %h want %h", data_out, VEC_P); else passed++;
    total++; if (ncyc != a_n + core_s + core_l + 1)
      $display("FAIL single_latency: got %0d want %0d", ncyc - a_n, core_s + core_l + 1);
    else passed++;
    tick();
    total++; if (!(done_a === 1'b0 && arb_busy === 1'b0 && data_out === VEC_P))
      $display("FAIL single_after: got done_a=%b busy=%b out=%h want 0 0 %h", done_a, arb_busy, data_out, VEC_P);
    else passed++;
  endtask

  task automatic test_fairness();
    bit found; int prio; int side; int d_n; logic [127:0] exp;
    do_reset();
    prio = 0; d_n = -1;
    core_mode = 0; core_s = $urandom_range(1, 3); core_l = $urandom_range(1, 6);
    data_a = rand128(); key_a = rand128(); data_b = rand128(); key_b = rand128();
    req_a = 1'b1; req_b = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_ev(0, 100, found);
      total++; if (!found) $display("FAIL fair_ack_seen: job %0d got none want ack", j); else passed++;
      side = (ack_b === 1'b1) ? 1 : 0;
      total++; if (side != prio || (ack_a === 1'b1 && ack_b === 1'b1))
        $display("FAIL fair_order: job %0d got ack_a=%b ack_b=%b want side %0d", j, ack_a, ack_b, prio);
      else passed++;
      if (d_n >= 0) begin
        total++; if (ncyc != d_n + 2) $display("FAIL fair_gap: got %0d want 2", ncyc - d_n); else passed++;
      end
      exp = (prio == 1) ? ref_plain(data_b, key_b) : ref_plain(data_a, key_a);
      if (prio == 1) begin data_b = rand128(); key_b = rand128(); end
      else begin data_a = rand128(); key_a = rand128(); end
      wait_ev(1, 100, found);
      total++; if (!(done_a === (prio == 0) && done_b === (prio == 1) && err === 1'b0))
        $display("FAIL fair_done: job %0d got done_a=%b done_b=%b err=%b want side %0d", j, done_a, done_b, err, prio);
      else passed++;
      total++; if (data_out !== exp) $display("FAIL fair_data: job %0d got %h want %h", j, data_out, exp); else passed++;
      d_n = ncyc;
      prio = 1 - prio;
      core_s = $urandom_range(1, 3); core_l = $urandom_range(1, 6);
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_ev(2, 50, found);
  endtask

  task automatic test_random();
    bit found, first; int m_prio, pat, pa, pb, exp_side, r, a_n; logic [127:0] exp;
    do_reset();
    m_prio = 0;
    for (int it = 0; it < 12; it++) begin
      core_mode = 0; core_s = $urandom_range(1, 4); core_l = $urandom_range(1, 10);
      wait_ev(3, 100, found);
      wait_ev(2, 100, found);
      pat = $urandom_range(1, 3); pa = pat & 1; pb = (pat >> 1) & 1;
      data_a = rand128(); key_a = rand128(); data_b = rand128(); key_b = rand128();
      req_a = (pa != 0); req_b = (pb != 0);
      r = ncyc; first = 1'b1;
      while (pa != 0 || pb != 0) begin
        exp_side = (pa != 0 && pb != 0) ? m_prio : ((pa != 0) ? 0 : 1);
        wait_ev(0, 60, found);
        total++; if (!found) begin
          $display("FAIL rand_ack_seen: iter %0d got none want ack", it);
          req_a = 1'b0; req_b = 1'b0; return;
        end else passed++;
        if (first) begin
          total++; if (ncyc != r + 1) $display("FAIL rand_ack_latency: got %0d want 1", ncyc - r); else passed++;
          first = 1'b0;
        end
        total++; if (!(ack_a === (exp_side == 0) && ack_b === (exp_side == 1)))
          $display("FAIL rand_grant: iter %0d got ack_a=%b ack_b=%b want side %0d", it, ack_a, ack_b, exp_side);
        else passed++;
        exp = (exp_side == 1) ? ref_plain(data_b, key_b) : ref_plain(data_a, key_a);
        a_n = ncyc;
        if (exp_side == 1) begin req_b = 1'b0; pb = 0; end else begin req_a = 1'b0; pa = 0; end
        wait_ev(1, 100, found);
        total++; if (!(done_a === (exp_side == 0) && done_b === (exp_side == 1) && err === 1'b0))
          $display("FAIL rand_done: iter %0d got done_a=%b done_b=%b err=%b want side %0d", it, done_a, done_b, err, exp_side);
        else passed++;
        total++; if (data_out !== exp) $display("FAIL rand_data: iter %0d got %h want %h", it, data_out, exp); else passed++;
        total++; if (ncyc != a_n + core_s + core_l + 1)
          $display("FAIL rand_latency: iter %0d got %0d want %0d", it, ncyc - a_n, core_s + core_l + 1);
        else passed++;
        m_prio = 1 - exp_side;
        core_s = $urandom_range(1, 4); core_l = $urandom_range(1, 10);
      end
    end
  endtask

  task automatic test_timeouts();
    int a_n; bit ga, gd; logic [127:0] d, k;
    // core never raises busy
    core_mode = 1;
    run_a(rand128(), rand128(), a_n, ga, gd);
    total++; if (!(ga && gd && done_a === 1'b1 && err === 1'b1))
      $display("FAIL stuck_abort: got ack=%b done=%b done_a=%b err=%b want 1 1 1 1", ga, gd, done_a, err);
    else passed++;
    total++; if (data_out !== '0) $display("FAIL stuck_data: got %h want 0", data_out); else passed++;
    total++; if (ncyc != a_n + T + 1) $display("FAIL stuck_time: got %0d want %0d", ncyc - a_n, T + 1); else passed++;
    tick();
    total++; if (!(arb_busy === 1'b0 && done_a === 1'b0))
      $display("FAIL stuck_idle: got busy=%b done_a=%b want 0 0", arb_busy, done_a);
    else passed++;
    // core never drops busy
    core_mode = 2; core_s = 2; core_l = 1;
    run_a(rand128(), rand128(), a_n, ga, gd);
    total++; if (!(gd && done_a === 1'b1 && err === 1'b1 && data_out === '0))
      $display("FAIL hung_abort: got done_a=%b err=%b out=%h want 1 1 0", done_a, err, data_out);
    else passed++;
    total++; if (ncyc != a_n + T + 2) $display("FAIL hung_time: got %0d want %0d", ncyc - a_n, T + 2); else passed++;
    core_mode = 0; clr_req++;
    core_s = 2; core_l = 4; d = rand128(); k = rand128();
    run_a(d, k, a_n, ga, gd);
    total++; if (!(gd && done_a === 1'b1 && err === 1'b0 && data_out === ref_plain(d, k)))
      $display("FAIL hung_recover: got err=%b out=%h want 0 %h", err, data_out, ref_plain(d, k));
    else passed++;
    // longest job that still completes
    core_s = 1; core_l = T; d = rand128(); k = rand128();
    run_a(d, k, a_n, ga, gd);
    total++; if (!(gd && err === 1'b0 && data_out === ref_plain(d, k) && ncyc == a_n + T + 2))
      $display("FAIL edge_ok: got err=%b out=%h t=%0d want 0 %h %0d", err, data_out, ncyc - a_n, ref_plain(d, k), T + 2);
    else passed++;
    // one cycle longer aborts
    core_l = T + 1;
    run_a(rand128(), rand128(), a_n, ga, gd);
    total++; if (!(gd && err === 1'b1 && data_out === '0 && ncyc == a_n + T + 2))
      $display("FAIL edge_abort: got err=%b out=%h t=%0d want 1 0 %0d", err, data_out, ncyc - a_n, T + 2);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit f; int a_n, bad; bit ga, gd; logic [127:0] d, k;
    core_mode = 0; core_s = 1; core_l = 40;
    wait_ev(3, 200, f);
    wait_ev(2, 200, f);
    data_a = rand128(); key_a = rand128(); req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (4) tick();
    total++; if (!(arb_busy === 1'b1 && dec_busy === 1'b1))
      $display("FAIL rstmid_busy: got arb=%b core=%b want 1 1", arb_busy, dec_busy);
    else passed++;
    n_rst = 1'b0;
    #1;
    total++; if ({dec_enable, ack_a, ack_b, done_a, done_b, err, owner, arb_busy} !== 8'h00)
      $display("FAIL rstmid_flags: got %b want 00000000", {dec_enable, ack_a, ack_b, done_a, done_b, err, owner, arb_busy});
    else passed++;
    total++; if (data_out !== '0 || dec_data !== '0 || dec_key !== '0)
      $display("FAIL rstmid_data: got %h/%h/%h want 0", data_out, dec_data, dec_key);
    else passed++;
    bad = 0;
    repeat (3) begin tick(); if (done_a === 1'b1 || done_b === 1'b1) bad++; end
    total++; if (bad != 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", bad); else passed++;
    n_rst = 1'b1;
    tick();
    core_s = 2; core_l = 3; d = rand128(); k = rand128();
    run_a(d, k, a_n, ga, gd);
    total++; if (!(ga && gd && done_a === 1'b1 && err === 1'b0 && data_out === ref_plain(d, k)))
      $display("FAIL rstmid_recover: got ack=%b done=%b err=%b out=%h want 1 1 0 %h", ga, gd, err, data_out, ref_plain(d, k));
    else passed++;
  endtask

  task automatic test_operand_stability();
    bit f, seen; logic [127:0] d0, k0;
    core_mode = 0; core_s = 2; core_l = 8;
    wait_ev(3, 200, f);
    wait_ev(2, 200, f);
    d0 = rand128(); k0 = rand128();
    data_a = d0; key_a = k0; req_a = 1'b1;
    tick();
    total++; if (ack_a !== 1'b1) $display("FAIL stab_ack: got %b want 1", ack_a); else passed++;
    req_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      data_a = rand128(); key_a = rand128();
      tick();
      total++; if (dec_data !== d0 || dec_key !== k0)
        $display("FAIL stab_operands: cycle %0d got %h/%h want %h/%h", i, dec_data, dec_key, d0, k0);
      else passed++;
      seen = (done_a === 1'b1);
    end
    total++; if (!seen) $display("FAIL stab_done_seen: got none want done_a"); else passed++;
    total++; if (data_out !== ref_plain(d0, k0) || err !== 1'b0)
      $display("FAIL stab_result: got %h err=%b want %h err=0", data_out, err, ref_plain(d0, k0));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_fairness();
    test_random();
    test_timeouts();
    test_reset_mid();
    test_operand_stability();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dec_arbiter.md
# dec_arbiter

Round-robin arbiter and sequencer that shares one `DecryptionBlock` between two requesters, A (SD read path) and B (host/bypass path). It latches the winning requester's 128-bit ciphertext and key and issues the one-cycle `enable_decrypt` pulse. It then tracks `dec_busy` through start and completion, returns the 128-bit plaintext with a done pulse to the owning requester, and aborts with an error if the core never starts or never finishes.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in WAIT_START plus WAIT_DONE before abort. Range 1..255.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  requester A asks for a decryption. Held until `ack_a`.
- `data_a`  in  128  requester A ciphertext. Sampled at grant.
- `key_a`  in  128  requester A key. Sampled at grant.
- `ack_a`  out  1  one-cycle pulse: A's operands captured.
- `done_a`  out  1  one-cycle pulse: A's result or error valid.
- `req_b`, `data_b`, `key_b`, `ack_b`, `done_b`: same as the A ports, for requester B.
- `data_out`  out  128  plaintext of the last completed job. Held until the next completion.
- `err`  out  1  valid with `done_x`: 1 = timeout abort.
- `owner`  out  1  0 = A, 1 = B. Meaningful while `arb_busy` is high.
- `arb_busy`  out  1  high in every state except IDLE.
- `dec_enable`  out  1  drives `enable_decrypt`.
- `dec_data`  out  128  drives `data_in`. Registered operand.
- `dec_key`  out  128  drives `key_in`. Registered operand.
- `dec_busy`  in  1  from `dec_busy`.
- `dec_result`  in  128  from `final_data_out`.

## Operation
- Five-state FSM: IDLE, LAUNCH, WAIT_START, WAIT_DONE, DELIVER. All outputs are registered or decoded from state (Moore).
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one of `req_a`/`req_b` high: grant that requester.
  - Both high: grant the side selected by the priority pointer `prio`.
  - On grant: latch the winner's data and key into `dec_data`/`dec_key`, set `owner`, clear the timeout counter, go to LAUNCH.
- **LAUNCH** (one cycle): `dec_enable`=1 and `ack_owner`=1, then go to WAIT_START.
- **WAIT_START**
  - `dec_busy`=1: go to WAIT_DONE.
  - Otherwise increment the counter. At count == TIMEOUT_CYCLES: set the error flag and go to DELIVER.
- **WAIT_DONE**
  - `dec_busy`=0: latch `dec_result` into `data_out`, clear the error flag, go to DELIVER.
  - Otherwise increment the counter. The timeout rule is the same as in WAIT_START; on abort, `data_out` is loaded with 0.
- **DELIVER** (one cycle): `done_owner`=1 and `err` equals the error flag. Set `prio` to the side not served, then go to IDLE.
- The counter is 8 bits and saturates; it never wraps.
- `dec_data`/`dec_key` stay stable from LAUNCH through DELIVER.
- Requests are sampled only in IDLE.
  - A `req` still high in IDLE after its `ack` counts as a new request.
  - A requester drops `req` in the cycle after `ack`.
- `done_x` and `ack_x` are never asserted for the non-owner.

## Timing
- Reset: state IDLE, `prio`=A. Every output is 0: `data_out`, `dec_data`, `dec_key`, `dec_enable`, `ack_*`, `done_*`, `err`, `owner`, `arb_busy`. The counter is also 0.
- Request sampled at edge k:
  - `ack`/`dec_enable` high in cycle k+1.
  - WAIT_START from edge k+2.
- Busy fall sampled at edge m: `done` and `data_out` valid in cycle m+1; IDLE at edge m+2.
- Back-to-back jobs: the next `dec_enable` comes no sooner than 2 cycles after the previous `done`.
- Arbiter overhead excluding core latency is 4 cycles from `req` to `done`.
- Reset mid-operation: immediate abort, no `done` pulse, all outputs cleared. `DecryptionBlock` shares `n_rst`.
- `dec_busy` glitching low in WAIT_START is ignored. Only a low sampled in WAIT_DONE counts as completion.

## Test plan
- Single A job:
  - Stimulus: `data_a`=deb0f81341f3503a7cd01e2bc7cdd556, `key_a`=5e74e7ba66b0c7cc1b7697b3f9f51527, with the real `DecryptionBlock`.
  - Required: `ack_a` exactly 1 cycle after the `req_a` sample; one `done_a` pulse; `data_out`=7d8ae0f7cfa0a6cb09fb5d05a8ec586d; `err`=0.
- Simultaneous `req_a`/`req_b` from reset, both held:
  - Required grant order A, B, A, B.
  - `done_b` carries B's plaintext; `done_a` is never seen during B's job.
- Stuck core: `dec_busy` held 0 with TIMEOUT_CYCLES=20.
  - Required: `done_a`=1 with `err`=1 exactly 20 cycles after entering WAIT_START; `data_out`=0; return to IDLE.
- Hung core: `dec_busy` held 1 forever.
  - Required: timeout abort with `err`=1.
  - A following normal job still completes with `err`=0.
- Reset during WAIT_DONE:
  - Required: all outputs 0 immediately; no `done`.
  - A new request after release completes correctly.
- Operand stability: change `data_a`/`key_a` every cycle after `ack_a`.
  - Required: `dec_data`/`dec_key` unchanged until DELIVER; result matches the originally granted operands.
